// File: rtl/mem_swap_ctrl.sv
// Exchanges the contents of two register-file locations: read A, read B, write A, write B, then done.
// Latency: 6 cycles from accepted start to the next acceptance (2 cycles when both addresses are equal).
// Backpressure: none; start is only sampled in IDLE and is ignored while busy, with no queuing.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               swap request, accepted only in IDLE
//   addr_a, addr_b      locations to exchange, latched on acceptance
//   busy, done          busy outside IDLE; done is a one-cycle pulse in DONE
//   swap_count          number of completed non-trivial swaps (wraps)
//   mem_we, mem_addr,   register-file write enable, shared read/write address,
//   mem_wdata           and write data
//   mem_rdata           register-file asynchronous read data for mem_addr
module mem_swap_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] tmp_a;
  logic [DATA_WIDTH-1:0] tmp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      swap_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= addr_a;
            b_q <= addr_b;
            // Equal addresses make the swap a no-op: skip all memory traffic.
            state <= (addr_a == addr_b) ? DONE : RD_A;
          end
        end
        RD_A: begin
          tmp_a <= mem_rdata;
          state <= RD_B;
        end
        RD_B: begin
          tmp_b <= mem_rdata;
          state <= WR_A;
        end
        WR_A: state <= WR_B;
        WR_B: begin
          swap_count <= swap_count + CNT_WIDTH'(1);
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from the registered state and latches only, so no input
  // reaches an output combinationally. In idle the address rests on a_q and
  // the write data rests on tmp_b, which gives all-zero outputs out of reset.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_we    = (state == WR_A) || (state == WR_B);
    mem_addr  = ((state == RD_B) || (state == WR_B)) ? b_q : a_q;
    mem_wdata = (state == WR_B) ? tmp_a : tmp_b;
  end

endmodule
